// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding a UART serialiser (8N1, LSB first) on the i_clk_uart domain.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits (8E1 frames).
module uart_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk_uart,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int              CLK_DIV   = CLK_FREQ / BAUD_RATE;
    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  EMPTY_CNT = {(PTR_W + 1){1'b0}};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_e;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // FIFO storage and bookkeeping
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [7:0]       fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             push_s;
    logic             pop_s;
    logic             fifo_nonempty_s;
    logic [7:0]       fifo_head_s;

    // Serialiser state
    state_e           state_q;
    state_e           state_d;
    logic [15:0]      baud_cnt_q;
    logic [15:0]      baud_cnt_d;
    logic [2:0]       bit_cnt_q;
    logic [2:0]       bit_cnt_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             baud_end_s;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    // Registered line outputs
    logic             tx_q;
    logic             tx_d;
    logic             done_q;
    logic             done_d;
    logic             busy_q;
    logic             busy_d;

    assign o_ready         = (count_q != FULL_CNT);
    assign push_s          = i_valid & o_ready;
    assign fifo_nonempty_s = (count_q != EMPTY_CNT);
    assign fifo_head_s     = fifo_mem_q[rd_ptr_q];
    assign baud_end_s      = (baud_cnt_q == BAUD_LAST);

    assign o_tx   = tx_q;
    assign o_done = done_q;
    assign o_busy = busy_q;

    // FIFO next-state: write on push, advance read pointer on pop
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = i_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
    end

    // FIFO registers
    always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fifo_mem_q <= '{default: 8'h00};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= EMPTY_CNT;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Frame sequencer: the line value is derived from the current state and registered,
    // so o_tx and o_done lag the state by one cycle (start bit appears one edge after the pop).
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop_s      = 1'b0;
        tx_d       = 1'b1;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d       = 1'b1;
                baud_cnt_d = 16'd0;
                if (fifo_nonempty_s) begin
                    pop_s    = 1'b1;
                    shift_d  = fifo_head_s;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_head_s);
`endif
                    state_d  = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_end_s) begin
                    baud_cnt_d = 16'd0;
                    bit_cnt_d  = 3'd0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (baud_end_s) begin
                    baud_cnt_d = 16'd0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (baud_end_s) begin
                    baud_cnt_d = 16'd0;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_end_s) begin
                    done_d     = 1'b1;
                    baud_cnt_d = 16'd0;
                    // Chain straight into the next start bit when more data is queued
                    if (fifo_nonempty_s) begin
                        pop_s    = 1'b1;
                        shift_d  = fifo_head_s;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_head_s);
`endif
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 3'd0;
            end
        endcase
        busy_d = (state_q != ST_IDLE) | fifo_nonempty_s;
    end

    // Sequencer and output registers; reset forces the line idle immediately
    always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLK_DIV = 10: directed steps plus a line-decoding monitor
// that pops expected bytes from a scoreboard queue filled when bytes are accepted.
module tb_uart_tx;

    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD_RATE  = 100000;
    localparam int FIFO_DEPTH = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int         n_asserts     = 0;
    int         n_fail        = 0;
    int         cyc           = 0;
    int         last_done_cyc = 0;
    bit         skip_frame    = 1'b0;
    bit         b2b_pend      = 1'b0;
    logic [7:0] sb [$];

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk_uart (clk),
        .i_rst_n    (rst_n),
        .i_data     (data),
        .i_valid    (valid),
        .o_ready    (ready),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a falling line edge; samples every bit at its midpoint
    task automatic decode_frame();
        logic [7:0] rx;
        logic [7:0] exp_b;
        int         start_cyc;
        #1;
        start_cyc = cyc;
        if (b2b_pend) chk_int("b2b_gap", start_cyc, last_done_cyc + 1);
        b2b_pend = 1'b0;
        chk_bit("frame_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) exp_b = sb.pop_front();
        else exp_b = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk_bit("start_bit", tx, 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat (10) @(posedge clk);
            #1;
            rx[k] = tx;
        end
        chk_byte("rx_byte", rx, exp_b);
`ifdef UART_TX_PARITY_EN
        repeat (10) @(posedge clk);
        #1;
        chk_bit("parity_bit", tx, ^exp_b);
`endif
        repeat (10) @(posedge clk);
        #1;
        chk_bit("stop_bit", tx, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk_bit("done_pulse", done, 1'b1);
        last_done_cyc = cyc;
        b2b_pend      = (sb.size() != 0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge tx);
            if (skip_frame) wait (!skip_frame);
            else decode_frame();
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_bit(tag, (n < 3000), 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [7:0] bytes6 [6];
        int         acc;
        int         first_full;
        bit         rdy;
        bit         bad;

        bytes6 = '{8'h11, 8'h22, 8'h5A, 8'h81, 8'hFE, 8'h3C};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_tx", tx, 1'b1);
        chk_bit("rst_ready", ready, 1'b1);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_bit("idle_tx", tx, 1'b1);

        // Single byte 0x55 pushed at edge N
        @(negedge clk);
        data  = 8'h55;
        valid = 1'b1;
        @(posedge clk);
        sb.push_back(8'h55);
        #1;
        valid = 1'b0;
        chk_bit("single_busy_N", busy, 1'b0);
        chk_bit("single_tx_N", tx, 1'b1);
        @(posedge clk);
        #1;
        chk_bit("single_busy_N1", busy, 1'b1);
        chk_bit("single_tx_N1", tx, 1'b1);
        @(posedge clk);
        #1;
        chk_bit("single_tx_N2", tx, 1'b0);
        repeat (98) @(posedge clk);
        #1;
        chk_bit("single_done_N100", done, 1'b0);
        @(posedge clk);
        #1;
        chk_bit("single_done_N101", done, 1'b1);
        chk_bit("single_busy_N101", busy, 1'b1);
        @(posedge clk);
        #1;
        chk_bit("single_done_N102", done, 1'b0);
        chk_bit("single_busy_N102", busy, 1'b0);
        drain("single_drain");

        // Back-to-back pushes
        @(negedge clk);
        data  = 8'hA3;
        valid = 1'b1;
        @(posedge clk);
        sb.push_back(8'hA3);
        @(negedge clk);
        data = 8'h0F;
        @(posedge clk);
        sb.push_back(8'h0F);
        #1;
        valid = 1'b0;
        drain("b2b_drain");

        // FIFO full: valid held high for six bytes
        acc        = 0;
        first_full = -1;
        @(negedge clk);
        data  = bytes6[0];
        valid = 1'b1;
        for (int t = 0; t < 400 && acc < 6; t++) begin
            rdy = ready;
            if (!rdy && first_full < 0) first_full = acc;
            @(posedge clk);
            if (rdy) begin
                sb.push_back(bytes6[acc]);
                acc++;
            end
            @(negedge clk);
            if (acc < 6) data = bytes6[acc];
        end
        valid = 1'b0;
        chk_int("full_after_accepts", first_full, 5);
        chk_int("full_all_accepted", acc, 6);
        drain("full_drain");

        // Reset during bit 3 of 0x00, with a second byte queued behind it
        skip_frame = 1'b1;
        @(negedge clk);
        data  = 8'h00;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data = 8'h11;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (46) @(posedge clk);
        #1;
        chk_bit("midframe_tx_low", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_bit("midframe_rst_tx", tx, 1'b1);
        chk_bit("midframe_rst_busy", busy, 1'b0);
        chk_bit("midframe_rst_ready", ready, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int t = 0; t < 250; t++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        chk_bit("no_frame_after_rst", bad, 1'b0);
        skip_frame = 1'b0;

        @(negedge clk);
        data  = 8'hC6;
        valid = 1'b1;
        @(posedge clk);
        sb.push_back(8'hC6);
        #1;
        valid = 1'b0;
        drain("post_rst_drain");

`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        data  = 8'h07;
        valid = 1'b1;
        @(posedge clk);
        sb.push_back(8'h07);
        #1;
        valid = 1'b0;
        drain("parity07_drain");
        @(negedge clk);
        data  = 8'h03;
        valid = 1'b1;
        @(posedge clk);
        sb.push_back(8'h03);
        #1;
        valid = 1'b0;
        drain("parity03_drain");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
